// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response signals and data RAM port
// of the memory-stage load/store unit.
//   slave  - the load/store unit itself
//   master - the pipeline plus data RAM side that talks to the unit
interface mem_access_unit_if #(
    parameter int addr_width = 10,
    parameter int data_width = 32
);
    // Pipeline request
    logic                  req_valid;
    logic                  is_load;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [31:0]           addr;
    logic [data_width-1:0] wdata;

    // Pipeline response
    logic                  stall;
    logic                  load_valid;
    logic [data_width-1:0] load_data;
    logic                  misalign_err;

    // Data RAM port
    logic [addr_width-1:0] daddr;
    logic                  MemWrite;
    logic                  MemRead;
    logic [data_width-1:0] ddata_w;
    logic [data_width-1:0] ddata_r;

    modport slave (
        input  req_valid, is_load, is_store, funct3, addr, wdata, ddata_r,
        output stall, load_valid, load_data, misalign_err,
               daddr, MemWrite, MemRead, ddata_w
    );

    modport master (
        output req_valid, is_load, is_store, funct3, addr, wdata, ddata_r,
        input  stall, load_valid, load_data, misalign_err,
               daddr, MemWrite, MemRead, ddata_w
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Converts byte/halfword/word loads and stores (signed or unsigned) into word
// accesses on the data RAM. Word stores complete in one cycle; loads take two
// cycles; sub-word stores are read-modify-write over two cycles. The pipeline
// is stalled while a multi-cycle access is in flight.
// Build option: define MISALIGN_TRAP_EN to reject misaligned halfword/word
// requests with a one-cycle misalign_err pulse. Without it, misaligned
// requests are aligned down to the access size and misalign_err stays 0.
module mem_access_unit #(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RMW_MERGE
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_t;

    // Everything the second cycle of a load or RMW store needs to remember.
    typedef struct packed {
        logic [addr_width-1:0] widx;
        logic [1:0]            off;
        logic [2:0]            funct3;
        logic [15:0]           data;
    } req_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t                state_q;
    state_t                state_d;
    req_t                  cur_req;
    req_t                  lat_q;
    acc_t                  acc;
    logic                  misaligned;
    logic                  capture;
    logic                  stall;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mis_err;
    logic [addr_width-1:0] daddr;
    logic [data_width-1:0] ddata_w;
    logic                  load_valid_q;
    logic [data_width-1:0] load_data_q;

    // Address bits above the RAM word index do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.addr[31:addr_width+2]};

    // Pick the addressed lanes out of a RAM word and extend them.
    function automatic logic [data_width-1:0] extract_load(
        input logic [data_width-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            funct3
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [data_width-1:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'h0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte or halfword lanes of a RAM word.
    function automatic logic [data_width-1:0] merge_store(
        input logic [data_width-1:0] word,
        input logic [1:0]            off,
        input logic [2:0]            funct3,
        input logic [15:0]           data
    );
        logic [data_width-1:0] res;
        res = word;
        if (funct3 == F3_B) begin
            res[{off, 3'b000} +: 8] = data[7:0];
        end else begin
            res[{off[1], 4'b0000} +: 16] = data;
        end
        return res;
    endfunction

    // Decode the incoming request: access size, lane offset, misalignment.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        acc            = ACC_NONE;
        misaligned     = 1'b0;
        cur_req.widx   = bus.addr[addr_width+1:2];
        cur_req.off    = bus.addr[1:0];
        cur_req.funct3 = bus.funct3;
        cur_req.data   = bus.wdata[15:0];

        // Load and store together is not a request at all.
        if (bus.req_valid && (bus.is_load != bus.is_store)) begin
            case (bus.funct3)
                F3_B:    acc = ACC_BYTE;
                F3_H:    acc = ACC_HALF;
                F3_W:    acc = ACC_WORD;
                F3_BU:   acc = bus.is_load ? ACC_BYTE : ACC_NONE;
                F3_HU:   acc = bus.is_load ? ACC_HALF : ACC_NONE;
                default: acc = ACC_NONE;
            endcase
        end

`ifdef MISALIGN_TRAP_EN
        misaligned = ((acc == ACC_HALF) && bus.addr[0]) ||
                     ((acc == ACC_WORD) && (bus.addr[1:0] != 2'b00));
`else
        if (acc == ACC_HALF) begin
            cur_req.off = {bus.addr[1], 1'b0};
        end else if (acc == ACC_WORD) begin
            cur_req.off = 2'b00;
        end
`endif
    end

    // Next state and all combinational outputs of the access sequencer.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        daddr     = '0;
        ddata_w   = '0;
        mis_err   = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc != ACC_NONE) begin
                    if (misaligned) begin
                        mis_err = 1'b1;
                    end else if (bus.is_store && (acc == ACC_WORD)) begin
                        mem_write = 1'b1;
                        daddr     = cur_req.widx;
                        ddata_w   = bus.wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        mem_read = 1'b1;
                        stall    = 1'b1;
                        daddr    = cur_req.widx;
                        capture  = 1'b1;
                        state_d  = bus.is_load ? LOAD_WAIT : RMW_MERGE;
                    end
                end
            end

            LOAD_WAIT: begin
                stall   = 1'b1;
                daddr   = lat_q.widx;
                state_d = IDLE;
            end

            RMW_MERGE: begin
                stall     = 1'b1;
                mem_write = 1'b1;
                daddr     = lat_q.widx;
                ddata_w   = merge_store(bus.ddata_r, lat_q.off, lat_q.funct3,
                                        lat_q.data);
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Reset wins over everything, so an access cut short mid-flight
        // never reaches the RAM.
        if (RESET) begin
            state_d   = IDLE;
            stall     = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            daddr     = '0;
            ddata_w   = '0;
            mis_err   = 1'b0;
            capture   = 1'b0;
        end
    end

    // State register and the request latched for the second access cycle.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and updates together.
        if (RESET) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                lat_q <= cur_req;
            end
        end
    end

    // Load result: captured from RAM read data at the end of LOAD_WAIT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            load_valid_q <= (state_q == LOAD_WAIT);
            if (state_q == LOAD_WAIT) begin
                load_data_q <= extract_load(bus.ddata_r, lat_q.off,
                                            lat_q.funct3);
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.load_valid   = load_valid_q;
    assign bus.load_data    = load_data_q;
    assign bus.misalign_err = mis_err;
    assign bus.daddr        = daddr;
    assign bus.MemWrite     = mem_write;
    assign bus.MemRead      = mem_read;
    assign bus.ddata_w      = ddata_w;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit.
// A table of requests is issued back-to-back against a behavioural data RAM;
// per-cycle handshake/RAM-port values are compared against the table, and
// expected load results go through a scoreboard queue that is checked when
// load_valid pulses. Hand-written sequences cover reset behaviour.
module tb_mem_access_unit;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef enum {K_NONE, K_SW, K_LOAD, K_RMW, K_MIS} kind_t;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        kind_t       kind;   // expected behaviour when aligned-down
        logic        mis;    // misaligned halfword/word request
        logic [9:0]  daddr;  // expected RAM word address
        logic [31:0] exp;    // load result, or RMW write data
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic  CLK;
    logic  RESET;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    vec_t  tbl[$];
    exp_t  sb_q[$];
    logic [31:0] ram [0:(1<<AW)-1];

    mem_access_unit_if #(.addr_width(AW), .data_width(DW)) bus ();

    mem_access_unit #(.addr_width(AW), .data_width(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural data RAM: read data valid in the cycle after MemRead.
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        bus.ddata_r = 32'h0;
    end
    always @(posedge CLK) begin
        if (bus.MemWrite) ram[bus.daddr] <= bus.ddata_w;
        if (bus.MemRead)  bus.ddata_r   <= ram[bus.daddr];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every load_valid pulse must match the oldest expected load,
    // both in data and in the cycle it arrives.
    always @(negedge CLK) begin
        #2;
        if (bus.load_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("load_valid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, ":data"}, bus.load_data, e.data);
                check({e.name, ":cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic drive_req(input logic v, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        bus.req_valid = v;
        bus.is_load   = ld;
        bus.is_store  = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        end
    endtask

    task automatic add(input string name, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input kind_t k, input logic mis,
                       input logic [9:0] da, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = a;
        v.wdata = wd; v.kind = k; v.mis = mis; v.daddr = da; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Present one request and check every cycle it occupies. The request is
    // held stable through the stalled cycle, as the pipeline would.
    task automatic issue(input vec_t v);
        kind_t k;
        k = v.kind;
`ifdef MISALIGN_TRAP_EN
        if (v.mis) k = K_MIS;
`endif
        @(negedge CLK);
        drive_req(1'b1, v.ld, v.st, v.f3, v.addr, v.wdata);
        #1;
        check({v.name, ":stall0"}, 32'(bus.stall),
              32'((k == K_LOAD) || (k == K_RMW)));
        check({v.name, ":rd0"}, 32'(bus.MemRead),
              32'((k == K_LOAD) || (k == K_RMW)));
        check({v.name, ":wr0"}, 32'(bus.MemWrite), 32'(k == K_SW));
        check({v.name, ":mis"}, 32'(bus.misalign_err), 32'(k == K_MIS));
        if (k == K_SW || k == K_LOAD || k == K_RMW)
            check({v.name, ":daddr0"}, 32'(bus.daddr), 32'(v.daddr));
        if (k == K_SW)
            check({v.name, ":wdata"}, bus.ddata_w, v.wdata);
        if (k == K_LOAD) begin
            exp_t e;
            e.name = v.name; e.data = v.exp; e.due = cyc + 2;
            sb_q.push_back(e);
        end
        if (k == K_LOAD || k == K_RMW) begin
            @(negedge CLK);
            #1;
            check({v.name, ":stall1"}, 32'(bus.stall), 32'd1);
            check({v.name, ":rd1"}, 32'(bus.MemRead), 32'd0);
            check({v.name, ":wr1"}, 32'(bus.MemWrite), 32'(k == K_RMW));
            if (k == K_RMW) begin
                check({v.name, ":daddr1"}, 32'(bus.daddr), 32'(v.daddr));
                check({v.name, ":merged"}, bus.ddata_w, v.exp);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ":stall"}, 32'(bus.stall), 32'd0);
        check({tag, ":rd"}, 32'(bus.MemRead), 32'd0);
        check({tag, ":wr"}, 32'(bus.MemWrite), 32'd0);
        check({tag, ":daddr"}, 32'(bus.daddr), 32'd0);
        check({tag, ":ddata_w"}, bus.ddata_w, 32'd0);
        check({tag, ":mis"}, 32'(bus.misalign_err), 32'd0);
        check({tag, ":lv"}, 32'(bus.load_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name       ld    st    f3      addr    wdata         kind    mis  daddr exp
        add("sw8",      1'b0, 1'b1, 3'b010, 32'h8,  32'hDEADBEEF, K_SW,   1'b0, 10'd2, 32'h0);
        add("lw8",      1'b1, 1'b0, 3'b010, 32'h8,  32'h0,        K_LOAD, 1'b0, 10'd2, 32'hDEADBEEF);
        add("sw0",      1'b0, 1'b1, 3'b010, 32'h0,  32'h80FF7F01, K_SW,   1'b0, 10'd0, 32'h0);
        add("lb3",      1'b1, 1'b0, 3'b000, 32'h3,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'hFFFFFF80);
        add("lbu3",     1'b1, 1'b0, 3'b100, 32'h3,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'h00000080);
        add("lh2",      1'b1, 1'b0, 3'b001, 32'h2,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'hFFFF80FF);
        add("lhu0",     1'b1, 1'b0, 3'b101, 32'h0,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'h00007F01);
        add("lw2_mis",  1'b1, 1'b0, 3'b010, 32'h2,  32'h0,        K_LOAD, 1'b1, 10'd0, 32'h80FF7F01);
        add("lh1_mis",  1'b1, 1'b0, 3'b001, 32'h1,  32'h0,        K_LOAD, 1'b1, 10'd0, 32'h00007F01);
        add("sw4",      1'b0, 1'b1, 3'b010, 32'h4,  32'h11223344, K_SW,   1'b0, 10'd1, 32'h0);
        add("sb5",      1'b0, 1'b1, 3'b000, 32'h5,  32'h000000AA, K_RMW,  1'b0, 10'd1, 32'h1122AA44);
        add("lw4a",     1'b1, 1'b0, 3'b010, 32'h4,  32'h0,        K_LOAD, 1'b0, 10'd1, 32'h1122AA44);
        add("sw4b",     1'b0, 1'b1, 3'b010, 32'h4,  32'h11223344, K_SW,   1'b0, 10'd1, 32'h0);
        add("sh6",      1'b0, 1'b1, 3'b001, 32'h6,  32'h1234BEEF, K_RMW,  1'b0, 10'd1, 32'hBEEF3344);
        add("lw4b",     1'b1, 1'b0, 3'b010, 32'h4,  32'h0,        K_LOAD, 1'b0, 10'd1, 32'hBEEF3344);
        add("sb0",      1'b0, 1'b1, 3'b000, 32'h0,  32'hFFFFFF5A, K_RMW,  1'b0, 10'd0, 32'h80FF7F5A);
        add("lb0",      1'b1, 1'b0, 3'b000, 32'h0,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'h0000005A);
        add("lh0",      1'b1, 1'b0, 3'b001, 32'h0,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'h00007F5A);
        add("rsv011",   1'b1, 1'b0, 3'b011, 32'h0,  32'hFFFFFFFF, K_NONE, 1'b0, 10'd0, 32'h0);
        add("rsv_sbu",  1'b0, 1'b1, 3'b100, 32'h0,  32'hFFFFFFFF, K_NONE, 1'b0, 10'd0, 32'h0);
        add("rsv_shu",  1'b0, 1'b1, 3'b101, 32'h4,  32'hFFFFFFFF, K_NONE, 1'b0, 10'd0, 32'h0);
        add("ld_and_st",1'b1, 1'b1, 3'b010, 32'h4,  32'hFFFFFFFF, K_NONE, 1'b0, 10'd0, 32'h0);
        add("lw4c",     1'b1, 1'b0, 3'b010, 32'h4,  32'h0,        K_LOAD, 1'b0, 10'd1, 32'hBEEF3344);
        add("lw0",      1'b1, 1'b0, 3'b010, 32'h0,  32'h0,        K_LOAD, 1'b0, 10'd0, 32'h80FF7F5A);
        add("lb6",      1'b1, 1'b0, 3'b000, 32'h6,  32'h0,        K_LOAD, 1'b0, 10'd1, 32'hFFFFFFEF);
        add("lhu6",     1'b1, 1'b0, 3'b101, 32'h6,  32'h0,        K_LOAD, 1'b0, 10'd1, 32'h0000BEEF);
        add("swc",      1'b0, 1'b1, 3'b010, 32'hC,  32'h11223344, K_SW,   1'b0, 10'd3, 32'h0);

        // Reset: a word store presented under RESET must not reach the RAM.
        RESET = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge CLK);
        drive_req(1'b1, 1'b0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        #1;
        check_quiet("reset");
        check("reset:load_data", bus.load_data, 32'h0);
        idle(1);
        @(negedge CLK);
        RESET = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check_quiet("post_reset");

        // Main table, issued back-to-back.
        foreach (tbl[i]) issue(tbl[i]);
        idle(3);

        // Reset during RMW_MERGE of a byte store: no write, RAM unchanged.
        @(negedge CLK);
        drive_req(1'b1, 1'b0, 1'b1, 3'b000, 32'hC, 32'h00000099);
        #1;
        check("rmw_rst:rd0", 32'(bus.MemRead), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rmw_rst:wr", 32'(bus.MemWrite), 32'd0);
        check("rmw_rst:stall", 32'(bus.stall), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check_quiet("rmw_rst_after");
        check("rmw_rst_after:load_data", bus.load_data, 32'h0);
        check("rmw_rst:ram", ram[3], 32'h11223344);

        // Reset during LOAD_WAIT: no load_valid may follow.
        @(negedge CLK);
        drive_req(1'b1, 1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
        #1;
        check("ld_rst:stall0", 32'(bus.stall), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("ld_rst:stall1", 32'(bus.stall), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check_quiet("ld_rst_after");
        idle(1);
        #1;
        check("ld_rst_after2:lv", 32'(bus.load_valid), 32'd0);

        // RAM word survived the aborted RMW; load_data then holds its value.
        begin
            vec_t v;
            v.name = "lwc"; v.ld = 1'b1; v.st = 1'b0; v.f3 = 3'b010;
            v.addr = 32'hC; v.wdata = 32'h0; v.kind = K_LOAD; v.mis = 1'b0;
            v.daddr = 10'd3; v.exp = 32'h11223344;
            issue(v);
        end
        idle(5);
        #1;
        check("load_data_hold", bus.load_data, 32'h11223344);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the pipelined core. It converts pipeline load/store requests (byte, halfword, word, signed or unsigned) into word accesses on the data RAM (`CLK`, `daddr`, `MemWrite`, `MemRead`, `ddata_w`, `ddata_r`). Sub-word stores are performed as read-modify-write. The unit stalls the pipeline while a multi-cycle access is in flight.

## Interface
- `addr_width`, 10: RAM word-address width.
- `data_width`, 32: RAM word width. Fixed at 32; other values are unsupported.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present this cycle.
- `is_load` in 1: request is a load.
- `is_store` in 1: request is a store. `is_load` and `is_store` both high is treated as no request.
- `funct3` in 3: RISC-V width code. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are loads only.
- `addr` in 32: byte address. The word index is `addr[addr_width+1:2]`.
- `wdata` in 32: store data, taken from its low bytes.
- `stall` out 1: pipeline must hold the request stable.
- `load_valid` out 1: one-cycle pulse; `load_data` is valid.
- `load_data` out 32: extended load result.
- `misalign_err` out 1: one-cycle pulse on a misaligned request.
- `daddr` out addr_width: RAM word address.
- `MemWrite` out 1: RAM write enable.
- `MemRead` out 1: RAM read enable.
- `ddata_w` out 32: RAM write data.
- `ddata_r` in 32: RAM read data, valid in the cycle after `MemRead`.

## Operation
- **States:** IDLE, LOAD_WAIT, RMW_MERGE.
- **Request acceptance:** a request is accepted only in IDLE. Requests are ignored in other states; upstream holds them stable under `stall`.
- **Lane mapping:** little-endian. Byte k occupies bits [8k+7:8k] and is selected by `addr[1:0]`. A halfword uses lanes `addr[1]`*2 and the next lane.
- **Word store (IDLE, funct3=010):**
  - `MemWrite`=1, `ddata_w`=`wdata`, `daddr` driven, all combinationally in the same cycle.
  - `stall`=0; remain in IDLE.
- **Load (IDLE):**
  - `MemRead`=1 and `stall`=1 combinationally; go to LOAD_WAIT.
  - In LOAD_WAIT: `stall`=1. At the end of the cycle, register the extracted lanes into `load_data` (sign-extended for B/H, zero-extended for BU/HU/W) and set `load_valid`=1. Go to IDLE.
- **Sub-word store (IDLE, funct3=000/001):**
  - `MemRead`=1 and `stall`=1; latch the address, data and width; go to RMW_MERGE.
  - In RMW_MERGE: `MemWrite`=1 and `stall`=1. `ddata_w` = `ddata_r` with only the addressed lanes replaced by `wdata[7:0]` or `wdata[15:0]`. Go to IDLE.
- **Reserved funct3:** 011, 110, 111, and BU/HU on a store, perform no access and raise no error.
- **Outputs held low:** `MemRead` and `MemWrite` are 0 in every cycle not listed above.

## Timing
- **Reset values:** state IDLE, `stall` 0, `load_valid` 0, `load_data` 0, `misalign_err` 0, `MemWrite` 0, `MemRead` 0, `daddr` 0, `ddata_w` 0.
- **Reset priority:** while `RESET` is high, `MemWrite` and `MemRead` are forced to 0 combinationally.
- **Reset mid-operation:** reset in LOAD_WAIT or RMW_MERGE aborts the access. No write occurs and no `load_valid` is produced.
- **Word store:** 1 cycle, no stall.
- **Load accepted in cycle N:** `stall` high in N and N+1; `load_valid` high in N+2 only.
- **Sub-word store accepted in cycle N:** read in N, write in N+1; `stall` high in N and N+1. The next request can be accepted in N+2.
- **Back-to-back:**
  - A load can be accepted in the cycle after a word store.
  - A load following an RMW store to the same word returns the merged value.
- **`load_data`:** holds its value until the next load completes.

## Configuration
- **`MISALIGN_TRAP_EN` defined:**
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, performs no RAM access.
  - `misalign_err` pulses high for the acceptance cycle; `stall`=0; remain in IDLE.
- **Not defined:**
  - Low address bits below the access size are forced to 0 (the access is aligned down).
  - `misalign_err` is tied to 0.

## Test plan
- **Word store/load round trip:** word store 0xDEADBEEF at addr 0x8 -> `MemWrite` for 1 cycle, `daddr`=2. Word load at 0x8 -> `load_valid` 2 cycles after acceptance, `load_data`=0xDEADBEEF.
- **Signed/unsigned byte and halfword loads:** word 0x80FF7F01 at addr 0.
  - LB @3 -> 0xFFFFFF80; LBU @3 -> 0x00000080.
  - LH @2 -> 0xFFFF80FF; LHU @0 -> 0x00007F01.
- **RMW byte store:** SB 0xAA @0x5 over word 0x11223344 -> RAM write 0x1122AA44 at `daddr`=1; `stall` high for exactly 2 cycles.
- **RMW halfword store followed by load:** SH 0xBEEF @0x6 over 0x11223344, then LW @0x4 -> `load_data`=0xBEEF3344.
- **Misalignment:** LW @0x2.
  - With `MISALIGN_TRAP_EN`: `misalign_err` pulses, no `MemRead`/`MemWrite`, `stall` 0.
  - Without it: reads the word at `daddr`=0.
- **Reset mid-operation:** assert `RESET` during RMW_MERGE of SB -> no `MemWrite`, state IDLE, all outputs at reset values the next cycle; RAM word unchanged.
